// File: rtl/button_event_ctrl.sv
// Button gesture decoder: turns a debounced button level into short-click,
// double-click, long-press and auto-repeat pulses using one shared timer.
module button_event_ctrl #(
  parameter int LONG_TOTAL   = 6000000,
  parameter int DCLICK_TOTAL = 3000000,
  parameter int REPEAT_TOTAL = 1200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic butd,
  input  logic en,
  output logic held,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse  // auto-repeat pulse; "repeat" is a reserved word
);

  // state    | meaning
  // IDLE     | waiting for a fresh press edge
  // PRESS1   | first press held, timing toward long_press
  // WAIT_GAP | released, timing the window for a second press
  // PRESS2   | second press of a double click, waiting for release
  // LONG     | long-held, emitting repeat pulses

  localparam int MAX_LD    = (LONG_TOTAL > DCLICK_TOTAL) ? LONG_TOTAL : DCLICK_TOTAL;
  localparam int MAX_TOTAL = (MAX_LD > REPEAT_TOTAL) ? MAX_LD : REPEAT_TOTAL;
  localparam int CW        = $clog2(MAX_TOTAL);

  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TOTAL - 1);
  localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_TOTAL - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TOTAL - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS1   = 3'd1,
    WAIT_GAP = 3'd2,
    PRESS2   = 3'd3,
    LONG     = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          butd_q;
  logic          press_edge;

  assign press_edge = butd & ~butd_q;

  // butd_q resets high so a button held through reset never looks like a new press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      butd_q       <= 1'b1;
      held         <= 1'b0;
      short_click  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      butd_q       <= butd;
      short_click  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;

      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
        held  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (press_edge) begin
              state <= PRESS1;
              cnt   <= '0;
              held  <= 1'b1;
            end else begin
              held  <= 1'b0;
            end
          end

          // butd is checked first everywhere: the button wins over any timer expiry
          PRESS1: begin
            if (!butd) begin
              state <= WAIT_GAP;
              cnt   <= '0;
              held  <= 1'b0;
            end else if (cnt == LONG_LAST) begin
              state      <= LONG;
              cnt        <= '0;
              long_press <= 1'b1;
              held       <= 1'b1;
            end else begin
              cnt  <= cnt + 1'b1;
              held <= 1'b1;
            end
          end

          WAIT_GAP: begin
            if (butd) begin
              state        <= PRESS2;
              cnt          <= '0;
              double_click <= 1'b1;
              held         <= 1'b1;
            end else if (cnt == DCLICK_LAST) begin
              state       <= IDLE;
              cnt         <= '0;
              short_click <= 1'b1;
              held        <= 1'b0;
            end else begin
              cnt  <= cnt + 1'b1;
              held <= 1'b0;
            end
          end

          PRESS2: begin
            if (!butd) begin
              state <= IDLE;
              held  <= 1'b0;
            end else begin
              held  <= 1'b1;
            end
          end

          LONG: begin
            if (!butd) begin
              state <= IDLE;
              cnt   <= '0;
              held  <= 1'b0;
            end else if (cnt == REPEAT_LAST) begin
              cnt          <= '0;
              repeat_pulse <= 1'b1;
              held         <= 1'b1;
            end else begin
              cnt  <= cnt + 1'b1;
              held <= 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
            held  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: timestamp-based gesture model checked every
// cycle, plus directed gestures with hand-computed event times.
module tb_button_event_ctrl;
  localparam int LT = 20;
  localparam int DT = 10;
  localparam int RT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic butd = 1'b0;
  logic en = 1'b1;
  logic held, short_click, double_click, long_press, repeat_pulse;

  always #5 clk = ~clk;

  button_event_ctrl #(.LONG_TOTAL(LT), .DCLICK_TOTAL(DT), .REPEAT_TOTAL(RT)) dut (
    .clk(clk), .rst_n(rst_n), .butd(butd), .en(en), .held(held),
    .short_click(short_click), .double_click(double_click),
    .long_press(long_press), .repeat_pulse(repeat_pulse)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit cmp_on = 1'b0;

  // Model: phase plus the edge number at which the phase (or last repeat base) began.
  localparam int M_IDLE = 0, M_FIRST = 1, M_GAP = 2, M_SECOND = 3, M_LONG = 4;
  int phase = M_IDLE;
  int t0 = 0;
  logic prev_b = 1'b1;
  logic [4:0] exp_v = '0;  // {held, short, double, long, repeat}

  always @(posedge clk or negedge rst_n) begin
    logic pe, s, d, l, r;
    if (!rst_n) begin
      phase  = M_IDLE;
      t0     = 0;
      prev_b = 1'b1;
      exp_v  = '0;
    end else begin
      cyc    = cyc + 1;
      pe     = butd && !prev_b;
      prev_b = butd;
      s = 0; d = 0; l = 0; r = 0;
      if (!en) phase = M_IDLE;
      else if (phase == M_IDLE) begin
        if (pe) begin phase = M_FIRST; t0 = cyc; end
      end else if (phase == M_FIRST) begin
        if (!butd) begin phase = M_GAP; t0 = cyc; end
        else if (cyc - t0 == LT) begin phase = M_LONG; t0 = cyc; l = 1; end
      end else if (phase == M_GAP) begin
        if (butd) begin phase = M_SECOND; d = 1; end
        else if (cyc - t0 == DT) begin phase = M_IDLE; s = 1; end
      end else if (phase == M_SECOND) begin
        if (!butd) phase = M_IDLE;
      end else begin
        if (!butd) phase = M_IDLE;
        else if ((cyc - t0) % RT == 0) r = 1;
      end
      exp_v = {(phase == M_FIRST || phase == M_SECOND || phase == M_LONG), s, d, l, r};
    end
  end

  int q_short[$], q_double[$], q_long[$], q_rpt[$];
  int held_cnt = 0;

  always @(negedge clk) begin
    if (cmp_on) begin
      compared++;
      if ({held, short_click, double_click, long_press, repeat_pulse} !== exp_v) begin
        mismatched++;
        $display("FAIL outputs cyc=%0d actual=%b required=%b", cyc,
                 {held, short_click, double_click, long_press, repeat_pulse}, exp_v);
      end
      if (short_click)  q_short.push_back(cyc);
      if (double_click) q_double.push_back(cyc);
      if (long_press)   q_long.push_back(cyc);
      if (repeat_pulse) q_rpt.push_back(cyc);
      if (held) held_cnt++;
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    q_short.delete(); q_double.delete(); q_long.delete(); q_rpt.delete();
    held_cnt = 0;
  endtask

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int pulses_total();
    return q_short.size() + q_double.size() + q_long.size() + q_rpt.size();
  endfunction

  initial begin
    int p, r, d;
    tick(2);
    cmp_on = 1'b1;
    tick(1);
    check("reset_outputs", {held, short_click, double_click, long_press, repeat_pulse}, 0);
    rst_n = 1'b1;
    tick(3);

    // single short click
    clear_logs();
    butd = 1; p = cyc + 1; tick(5);
    butd = 0; r = cyc + 1; tick(20);
    check("t1_short_count", q_short.size(), 1);
    check("t1_short_at", q_short.size() > 0 ? q_short[0] : -1, r + 10);
    check("t1_release_edge", r, p + 5);
    check("t1_held_cycles", held_cnt, 5);
    check("t1_other_pulses", q_double.size() + q_long.size() + q_rpt.size(), 0);

    // double click
    clear_logs();
    butd = 1; tick(5);
    butd = 0; tick(4);
    butd = 1; d = cyc + 1; tick(5);
    butd = 0; tick(15);
    check("t2_double_count", q_double.size(), 1);
    check("t2_double_at", q_double.size() > 0 ? q_double[0] : -1, d);
    check("t2_short_count", q_short.size(), 0);
    check("t2_held_cycles", held_cnt, 10);
    check("t2_idle_held", held, 0);

    // long press with repeats
    clear_logs();
    butd = 1; p = cyc + 1; tick(40);
    butd = 0; tick(15);
    check("t3_long_count", q_long.size(), 1);
    check("t3_long_at", q_long.size() > 0 ? q_long[0] : -1, p + 20);
    check("t3_rpt_count", q_rpt.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t3_rpt%0d_at", i), q_rpt.size() > i ? q_rpt[i] : -1, p + 25 + 5 * i);
    check("t3_short_double", q_short.size() + q_double.size(), 0);
    check("t3_held_cycles", held_cnt, 40);

    // release exactly at long threshold, re-press exactly at gap timeout
    clear_logs();
    butd = 1; p = cyc + 1; tick(20);
    butd = 0; tick(10);
    butd = 1; d = cyc + 1; tick(3);
    butd = 0; tick(15);
    check("t4_long_count", q_long.size(), 0);
    check("t4_double_count", q_double.size(), 1);
    check("t4_double_at", q_double.size() > 0 ? q_double[0] : -1, p + 30);
    check("t4_short_count", q_short.size(), 0);

    // reset mid-press with button held
    butd = 1; tick(8);
    rst_n = 0; tick(2);
    rst_n = 1; clear_logs(); tick(30);
    check("t5_no_pulses", pulses_total(), 0);
    check("t5_no_held", held_cnt, 0);
    butd = 0; tick(3);
    clear_logs();
    butd = 1; tick(3);
    butd = 0; r = cyc + 1; tick(15);
    check("t5_short_at", q_short.size() > 0 ? q_short[0] : -1, r + 10);
    check("t5_held_cycles", held_cnt, 3);

    // reset mid-gap discards the pending short click
    butd = 1; tick(3);
    butd = 0; tick(4);
    rst_n = 0; tick(1);
    rst_n = 1; clear_logs(); tick(20);
    check("t6_no_short", pulses_total(), 0);

    // en dropped mid-press, button held across en rising
    butd = 1; tick(8);
    en = 0; tick(3);
    en = 1; clear_logs(); tick(30);
    check("t7_no_pulses", pulses_total(), 0);
    check("t7_no_held", held_cnt, 0);
    butd = 0; tick(3);
    clear_logs();
    butd = 1; p = cyc + 1; tick(25);
    butd = 0; tick(5);
    check("t7_long_at", q_long.size() > 0 ? q_long[0] : -1, p + 20);
    check("t7_held_cycles", held_cnt, 25);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 The block SHALL provide parameter LONG_TOTAL, default 6000000, meaning held-press cycles before long_press (0.5 s at 12 MHz).
REQ-002 The block SHALL provide parameter DCLICK_TOTAL, default 3000000, meaning the release-gap window in cycles for double-click detection (0.25 s).
REQ-003 The block SHALL provide parameter REPEAT_TOTAL, default 1200000, meaning the auto-repeat period in cycles while long-held (0.1 s).
REQ-004 The block SHALL have port clk, input, 1, the system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, the reset, asynchronous and active-low.
REQ-006 The block SHALL have port butd, input, 1, the debounced button level synchronous to clk, where 1 = pressed.
REQ-007 The block SHALL have port en, input, 1, the enable; when low, event detection is disabled.
REQ-008 The block SHALL have port held, output, 1, high while the state is PRESS1, PRESS2 or LONG.
REQ-009 The block SHALL have ports short_click, double_click, long_press and repeat, each an output of width 1 carrying a one-cycle event pulse.

Function
REQ-010 The block SHALL support all parameters >= 2; the shared counter SHALL be $clog2(max(LONG_TOTAL, DCLICK_TOTAL, REPEAT_TOTAL)) bits wide.
REQ-011 The block SHALL register butd into butd_q every cycle; a press edge is butd=1 with butd_q=0.
REQ-012 The block SHALL implement states IDLE, PRESS1, WAIT_GAP, PRESS2 and LONG in one counter-driven FSM, with all outputs registered.
REQ-013 In IDLE, a press edge SHALL cause a transition to PRESS1 with cnt=0; otherwise the block SHALL stay in IDLE.
REQ-014 In PRESS1, butd=0 SHALL cause a transition to WAIT_GAP with cnt=0; otherwise, if cnt==LONG_TOTAL-1, the block SHALL go to LONG with cnt=0 and assert long_press for the next cycle; otherwise cnt SHALL increment.
REQ-015 In WAIT_GAP, butd=1 SHALL cause a transition to PRESS2 and assert double_click for the next cycle; otherwise, if cnt==DCLICK_TOTAL-1, the block SHALL go to IDLE and assert short_click for the next cycle; otherwise cnt SHALL increment.
REQ-016 In PRESS2, butd=0 SHALL cause a transition to IDLE; no timeout and no long detection SHALL apply in PRESS2.
REQ-017 In LONG, butd=0 SHALL cause a transition to IDLE with no pulse; otherwise, if cnt==REPEAT_TOTAL-1, the block SHALL assert repeat for the next cycle with cnt=0; otherwise cnt SHALL increment.
REQ-018 Simultaneous events SHALL be resolved in favour of butd: release beats the long threshold in PRESS1, a press beats the timeout in WAIT_GAP, and release beats a repeat in LONG.
REQ-019 The block SHALL assert at most one event pulse in any cycle; each pulse SHALL be exactly one cycle wide.
REQ-020 Latency: long_press SHALL be high in the cycle starting LONG_TOTAL edges after the edge that sampled the press edge.
REQ-021 The first repeat SHALL follow long_press by REPEAT_TOTAL cycles, with subsequent repeats every REPEAT_TOTAL cycles.
REQ-022 en=0 SHALL synchronously force IDLE with cnt=0 and all pulses 0; a button held across the en rising transition SHALL be ignored until it is released and pressed again.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state=IDLE, cnt=0, butd_q=1, and held, short_click, double_click, long_press and repeat all to 0.
REQ-024 Because butd_q resets to 1, a button held through reset deassertion SHALL generate no event until it is released and pressed again.
REQ-025 Reset asserted mid-press or mid-gap SHALL discard the pending event, with no pulse on the subsequent release.

Verification (LONG_TOTAL=20, DCLICK_TOTAL=10, REPEAT_TOTAL=5)
REQ-026 Press 5 cycles, then release -> held high for 5 cycles; exactly one short_click, asserted 10 cycles after the release is sampled; no other pulses.
REQ-027 Press 5, release 4, press 5, release -> exactly one double_click, asserted on entry to PRESS2; no short_click; the state is IDLE after the final release.
REQ-028 Press held 40 cycles -> long_press at cycle 20 after the press edge, repeat at cycles 25, 30 and 35; no pulse on release.
REQ-029 Boundary: release on the cycle cnt==LONG_TOTAL-1 -> WAIT_GAP with no long_press; a second press on the cycle cnt==DCLICK_TOTAL-1 -> double_click and no short_click.
REQ-030 Assert rst_n mid-PRESS1 with butd held, then deassert -> all outputs 0 and no events until butd falls and rises again; repeat the check with en toggled low then high.
